// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry circular FIFO with stall backpressure,
// mispredict flush and suppression of the repeated HLT stream after main returns.
module fetch_queue #(
  parameter int          DEPTH        = 4,
  parameter int          GPR_SIZE     = 64,
  parameter logic [31:0] INSNBITS_HLT = 32'hD440_0000
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_f_done,
  input  logic [GPR_SIZE-1:0]        in_f_pc,
  input  logic [31:0]                in_f_insnbits,
  input  logic                       in_rob_mispredict,
  input  logic                       in_d_ready,
  output logic                       out_f_stall,
  output logic                       out_d_valid,
  output logic [GPR_SIZE-1:0]        out_d_pc,
  output logic [31:0]                out_d_insnbits,
  output logic [$clog2(DEPTH):0]     out_count
);

  localparam int               PW       = $clog2(DEPTH);
  localparam int               CW       = PW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic [GPR_SIZE-1:0] pc_mem_q   [DEPTH];
  logic [31:0]         insn_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          halted_q, halted_d;

  logic enq_s;
  logic deq_s;
  logic empty_s;

  // Handshake decode and head presentation; empty queue presents zeros.
  always_comb begin
    empty_s        = (count_q == {CW{1'b0}});
    out_f_stall    = (count_q == FULL_CNT);
    out_d_valid    = ~empty_s & ~in_rob_mispredict;
    out_count      = count_q;
    enq_s          = in_f_done & ~out_f_stall & ~halted_q & ~in_rob_mispredict & ~in_rst;
    deq_s          = out_d_valid & in_d_ready;
    if (empty_s) begin
      out_d_pc       = {GPR_SIZE{1'b0}};
      out_d_insnbits = 32'h0000_0000;
    end else begin
      out_d_pc       = pc_mem_q[head_q];
      out_d_insnbits = insn_mem_q[head_q];
    end
  end

  // Next-state pointers, occupancy and halt flag; reset and mispredict both flush.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (in_rst || in_rob_mispredict) begin
      head_d   = {PW{1'b0}};
      tail_d   = {PW{1'b0}};
      count_d  = {CW{1'b0}};
      halted_d = 1'b0;
    end else begin
      if (enq_s) begin
        tail_d = tail_q + PTR_ONE;
        if (in_f_insnbits == INSNBITS_HLT) begin
          halted_d = 1'b1;
        end else begin
          halted_d = halted_q;
        end
      end else begin
        tail_d = tail_q;
      end
      if (deq_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      head_q   <= {PW{1'b0}};
      tail_q   <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      halted_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Entry storage; contents are only observable through count, so no reset is needed.
  always_ff @(posedge in_clk) begin
    if (enq_s) begin
      pc_mem_q[tail_q]   <= in_f_pc;
      insn_mem_q[tail_q] <= in_f_insnbits;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, GPR_SIZE=64).
module tb_fetch_queue;

  localparam logic [31:0] HLT = 32'hD440_0000;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_f_done;
  logic [63:0] in_f_pc;
  logic [31:0] in_f_insnbits;
  logic        in_rob_mispredict;
  logic        in_d_ready;
  logic        out_f_stall;
  logic        out_d_valid;
  logic [63:0] out_d_pc;
  logic [31:0] out_d_insnbits;
  logic [2:0]  out_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  fetch_queue #(.DEPTH(4), .GPR_SIZE(64), .INSNBITS_HLT(HLT)) dut (
    .in_clk            (in_clk),
    .in_rst            (in_rst),
    .in_f_done         (in_f_done),
    .in_f_pc           (in_f_pc),
    .in_f_insnbits     (in_f_insnbits),
    .in_rob_mispredict (in_rob_mispredict),
    .in_d_ready        (in_d_ready),
    .out_f_stall       (out_f_stall),
    .out_d_valid       (out_d_valid),
    .out_d_pc          (out_d_pc),
    .out_d_insnbits    (out_d_insnbits),
    .out_count         (out_count)
  );

  always #5 in_clk = ~in_clk;

  // Advance one edge and settle 1ns after it.
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive(input logic done, input logic [63:0] pc, input logic [31:0] insn,
                       input logic ready, input logic misp);
    in_f_done = done; in_f_pc = pc; in_f_insnbits = insn;
    in_d_ready = ready; in_rob_mispredict = misp;
    #1;
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    in_rst = 1'b0;
    #1;
    vec_cnt++; if (out_d_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", out_d_valid); end
    vec_cnt++; if (out_f_stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall got=%b exp=0", out_f_stall); end
    vec_cnt++; if (out_count !== 3'd0) begin err_cnt++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    vec_cnt++; if (out_d_pc !== 64'h0) begin err_cnt++; $display("FAIL reset_pc got=%h exp=0", out_d_pc); end
    vec_cnt++; if (out_d_insnbits !== 32'h0) begin err_cnt++; $display("FAIL reset_insn got=%h exp=0", out_d_insnbits); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 64'h40_0000 + 64'(4 * k), 32'h1000 + 32'(k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 64'h40_0010, 32'h1004, 1'b0, 1'b0);
    vec_cnt++; if (out_count !== 3'd4) begin err_cnt++; $display("FAIL fill_count got=%0d exp=4", out_count); end
    vec_cnt++; if (out_f_stall !== 1'b1) begin err_cnt++; $display("FAIL fill_stall got=%b exp=1", out_f_stall); end
    tick();
    vec_cnt++; if (out_count !== 3'd4) begin err_cnt++; $display("FAIL fill_fifth_count got=%0d exp=4", out_count); end
    vec_cnt++; if (out_d_pc !== 64'h40_0000) begin err_cnt++; $display("FAIL fill_head got=%h exp=400000", out_d_pc); end
  endtask

  task automatic test_full_simul();
    logic [63:0] exp_pc [4];
    exp_pc[0] = 64'h40_0004; exp_pc[1] = 64'h40_0008; exp_pc[2] = 64'h40_000C; exp_pc[3] = 64'h40_0014;
    drive(1'b1, 64'h40_0010, 32'h2000, 1'b1, 1'b0);
    vec_cnt++; if (out_f_stall !== 1'b1) begin err_cnt++; $display("FAIL simul_stall got=%b exp=1", out_f_stall); end
    vec_cnt++; if (out_d_valid !== 1'b1) begin err_cnt++; $display("FAIL simul_valid got=%b exp=1", out_d_valid); end
    tick();
    vec_cnt++; if (out_count !== 3'd3) begin err_cnt++; $display("FAIL simul_count got=%0d exp=3", out_count); end
    vec_cnt++; if (out_f_stall !== 1'b0) begin err_cnt++; $display("FAIL simul_unstall got=%b exp=0", out_f_stall); end
    drive(1'b1, 64'h40_0014, 32'h2001, 1'b0, 1'b0);
    tick();
    vec_cnt++; if (out_count !== 3'd4) begin err_cnt++; $display("FAIL simul_resume got=%0d exp=4", out_count); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      vec_cnt++; if (out_d_pc !== exp_pc[k]) begin err_cnt++; $display("FAIL simul_drain%0d got=%h exp=%h", k, out_d_pc, exp_pc[k]); end
      tick();
    end
    vec_cnt++; if (out_count !== 3'd0) begin err_cnt++; $display("FAIL simul_empty got=%0d exp=0", out_count); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 64'h1000 + 64'(4 * k), 32'h3000 + 32'(k), 1'b1, 1'b0);
      if (k == 0) begin
        vec_cnt++; if (out_d_valid !== 1'b0) begin err_cnt++; $display("FAIL stream_first_valid got=%b exp=0", out_d_valid); end
      end else begin
        vec_cnt++; if (out_d_valid !== 1'b1 || out_d_pc !== 64'h1000 + 64'(4 * (k - 1)))
          begin err_cnt++; $display("FAIL stream_pc%0d got=%b/%h exp=1/%h", k, out_d_valid, out_d_pc, 64'h1000 + 64'(4 * (k - 1))); end
      end
      vec_cnt++; if (out_f_stall !== 1'b0 || out_count > 3'd1)
        begin err_cnt++; $display("FAIL stream_occ%0d got=stall %b count %0d exp=stall 0 count<=1", k, out_f_stall, out_count); end
      tick();
    end
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    vec_cnt++; if (out_d_pc !== 64'h1024) begin err_cnt++; $display("FAIL stream_last got=%h exp=1024", out_d_pc); end
    tick();
    vec_cnt++; if (out_count !== 3'd0) begin err_cnt++; $display("FAIL stream_empty got=%0d exp=0", out_count); end
  endtask

  task automatic test_mispredict();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'h100 + 64'(4 * k), 32'h4000, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 64'h2000, 32'h4001, 1'b1, 1'b1);
    vec_cnt++; if (out_d_valid !== 1'b0) begin err_cnt++; $display("FAIL misp_valid got=%b exp=0", out_d_valid); end
    tick();
    drive(1'b1, 64'h3000, 32'h4002, 1'b0, 1'b0);
    vec_cnt++; if (out_count !== 3'd0) begin err_cnt++; $display("FAIL misp_count got=%0d exp=0", out_count); end
    vec_cnt++; if (out_d_valid !== 1'b0 || out_d_pc !== 64'h0) begin err_cnt++; $display("FAIL misp_flush got=%b/%h exp=0/0", out_d_valid, out_d_pc); end
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    vec_cnt++; if (out_d_valid !== 1'b1 || out_d_pc !== 64'h3000 || out_count !== 3'd1)
      begin err_cnt++; $display("FAIL misp_refill got=%b/%h/%0d exp=1/3000/1", out_d_valid, out_d_pc, out_count); end
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_halt();
    drive(1'b1, 64'h1008, HLT, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 64'h100C + 64'(4 * k), HLT, 1'b0, 1'b0);
      tick();
      vec_cnt++; if (out_count !== 3'd1) begin err_cnt++; $display("FAIL halt_hold%0d got=%0d exp=1", k, out_count); end
    end
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    vec_cnt++; if (out_d_pc !== 64'h1008 || out_d_insnbits !== HLT)
      begin err_cnt++; $display("FAIL halt_head got=%h/%h exp=1008/%h", out_d_pc, out_d_insnbits, HLT); end
    tick();
    vec_cnt++; if (out_count !== 3'd0 || out_d_valid !== 1'b0) begin err_cnt++; $display("FAIL halt_drain got=%0d/%b exp=0/0", out_count, out_d_valid); end
    drive(1'b1, 64'h500, 32'h5000, 1'b0, 1'b0);
    tick();
    vec_cnt++; if (out_count !== 3'd0) begin err_cnt++; $display("FAIL halt_drop got=%0d exp=0", out_count); end
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 64'h500, 32'h5000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    vec_cnt++; if (out_count !== 3'd1 || out_d_pc !== 64'h500) begin err_cnt++; $display("FAIL halt_clear got=%0d/%h exp=1/500", out_count, out_d_pc); end
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 64'h600, 32'h6000, 1'b0, 1'b0); tick();
    drive(1'b1, 64'h604, 32'h6001, 1'b0, 1'b0); tick();
    vec_cnt++; if (out_count !== 3'd2) begin err_cnt++; $display("FAIL rstmid_pre got=%0d exp=2", out_count); end
    in_rst = 1'b1;
    drive(1'b1, 64'h700, 32'h7000, 1'b0, 1'b0);
    tick();
    in_rst = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    vec_cnt++; if (out_count !== 3'd0 || out_d_valid !== 1'b0 || out_d_pc !== 64'h0)
      begin err_cnt++; $display("FAIL rstmid_flush got=%0d/%b/%h exp=0/0/0", out_count, out_d_valid, out_d_pc); end
    drive(1'b1, 64'h800, 32'h8000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    vec_cnt++; if (out_count !== 3'd1 || out_d_pc !== 64'h800) begin err_cnt++; $display("FAIL rstmid_after got=%0d/%h exp=1/800", out_count, out_d_pc); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_simul();
    test_stream();
    test_mispredict();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer on the receiving end of the fetch-to-decode interface.
- Accepts the per-cycle {done, pc, insnbits} bundle produced by fetch and stores it in a DEPTH-entry circular FIFO.
- Presents the oldest entry to decode with a valid/ready handshake and backpressures fetch through a stall signal.
- Flushes all contents on a ROB mispredict, and suppresses the repeated HLT stream fetch emits after returning from main.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- GPR_SIZE, 64, PC width; equals `GPR_SIZE.

Ports:
- in_clk  input  1  clock; all state updates on posedge.
- in_rst  input  1  synchronous, active-high reset.
- in_f_done  input  1  fetch bundle valid this cycle.
- in_f_pc  input  GPR_SIZE  PC of the fetched instruction.
- in_f_insnbits  input  32  instruction bits (INSNBITS_HLT when fetch returned from main).
- in_rob_mispredict  input  1  flush request from ROB.
- in_d_ready  input  1  decode accepts the head entry this cycle.
- out_f_stall  output  1  queue full; fetch must hold PC this cycle.
- out_d_valid  output  1  head entry valid.
- out_d_pc  output  GPR_SIZE  head PC.
- out_d_insnbits  output  32  head instruction bits.
- out_count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (in_clk, in_rst).
- State: entry array (pc, insnbits), head_ptr, tail_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count, halted flag.
- Reset (in_rst=1 at posedge): head_ptr=tail_ptr=0, count=0, halted=0. Outputs after reset: out_d_valid=0, out_f_stall=0, out_count=0, out_d_pc=0, out_d_insnbits=0. Enqueue is blocked in any cycle with in_rst=1. Reset mid-operation discards all entries.
- Combinational outputs:
  - out_f_stall = (count==DEPTH).
  - out_d_valid = (count!=0) & ~in_rob_mispredict.
  - out_d_pc and out_d_insnbits = head entry when count!=0, else 0.
  - out_count = count.
- Enqueue condition: enq = in_f_done & ~out_f_stall & ~halted & ~in_rob_mispredict & ~in_rst. When enq is true, write {in_f_pc, in_f_insnbits} to tail_ptr and advance tail_ptr.
- Dequeue condition: deq = out_d_valid & in_d_ready. When deq is true, advance head_ptr.
- Count update: count += enq - deq. Simultaneous enq and deq leaves count unchanged.
- Full: no bypass. At count==DEPTH, stall is asserted even if decode dequeues in the same cycle; enqueue resumes the following cycle.
- Empty: no bypass. An entry enqueued at edge N is first visible (out_d_valid=1) in the cycle after edge N. Minimum latency is 1 cycle.
- Halt:
  - When an enqueued word equals INSNBITS_HLT, halted is set to 1 at that edge.
  - While halted, in_f_done bundles are dropped.
  - Entries already queued, including the HLT, drain normally.
  - halted clears only on in_rst or in_rob_mispredict.
- Mispredict (in_rob_mispredict=1 at posedge):
  - head_ptr=tail_ptr=0, count=0, halted=0.
  - No enqueue: that cycle's fetch bundle is wrong-path, because fetch redirects PC at the same edge.
  - No dequeue: out_d_valid is forced to 0 in that cycle.
  - First correct-path enqueue can occur in the next cycle.
  - Mispredict together with in_rst behaves as reset.
- Wrap-around: pointers roll from DEPTH-1 to 0; FIFO order is preserved across the wrap.
- in_f_pc values are stored verbatim; no arithmetic is performed on them.

Test Plan:
- Reset then fill, DEPTH=4: in_d_ready=0, four bundles pc=0x400000,0x400004,0x400008,0x40000C -> out_count=4, out_f_stall=1. A fifth bundle (0x400010) is not stored. out_d_pc=0x400000 throughout.
- Streaming with wrap: in_d_ready=1, ten consecutive bundles pc=0x1000+4k -> out_d_pc sequence 0x1000..0x1024, each appearing exactly once in order, one cycle after its enqueue. out_count stays ≤1 and never stalls.
- Simultaneous enq/deq at full: count=4, in_d_ready=1, in_f_done=1 -> stall=1 and that bundle is dropped. count=3 next cycle. Stall=0 and the enqueue succeeds the cycle after.
- Mispredict flush: three entries queued; assert in_rob_mispredict with in_f_done=1 and pc=0x2000 -> out_d_valid=0 that cycle. count=0 next cycle, and 0x2000 is not stored. Then pc=0x3000 -> out_d_pc=0x3000 one cycle later.
- Halt suppression: enqueue pc=0x1008 with INSNBITS_HLT, then hold in_f_done=1 with HLT for 5 cycles -> exactly one HLT entry is stored and drained, and out_count returns to 0. A subsequent mispredict clears halted and pc=0x500 is accepted.
- Reset mid-operation: count=2, in_rst=1 with in_f_done=1 -> count=0, out_d_valid=0 next cycle, and nothing is enqueued during the reset cycle.
